fsub_issue_wb: RTL and testbench

// Issue/writeback shell for the pipelined fsub unit. Accepts tagged operand pairs on a

---
 rtl/fsub_issue_wb.sv | 153 +++++++++++++++
 tb/tb_fsub_issue_wb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsub_issue_wb.sv
// fsub_issue_wb
// Issue/writeback shell around the pipelined fsub unit. Operand pairs arrive
// tagged on a valid/ready issue port. They are registered towards the fsub,
// and their tags are tracked through an NSTAGE-deep shift register. Results
// are captured when the fsub strobes enable_out and are queued in a
// first-word-fall-through FIFO. The FIFO returns them, in order, on a
// valid/ready result port.
//
// Ports
//   clk, rstn                      clock (rising edge), synchronous active-low reset
//   iss_valid/iss_ready            issue handshake
//   iss_x1, iss_x2, iss_tag        minuend, subtrahend, destination tag
//   fpu_x1, fpu_x2, fpu_enable_in  registered operands and issue strobe to the fsub
//   fpu_enable_out, fpu_y, fpu_ovf result strobe, value and overflow from the fsub
//   res_valid/res_ready            result handshake (FIFO head)
//   res_y, res_ovf, res_tag        result at the FIFO head (zero while empty)
//   proto_err                      sticky flag for fsub strobe mismatches or FIFO overrun
module fsub_issue_wb #(
    parameter int NSTAGE = 2,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [31:0]     iss_x1,
    input  logic [31:0]     iss_x2,
    input  logic [TAGW-1:0] iss_tag,
    output logic [31:0]     fpu_x1,
    output logic [31:0]     fpu_x2,
    output logic            fpu_enable_in,
    input  logic            fpu_enable_out,
    input  logic [31:0]     fpu_y,
    input  logic            fpu_ovf,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_y,
    output logic            res_ovf,
    output logic [TAGW-1:0] res_tag,
    output logic            proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + NSTAGE + 1);

    logic [31:0]     fpuX1_q, fpuX2_q;
    logic            fpuEnIn_q;
    logic [NSTAGE-1:0] trackVld_q;
    logic [TAGW-1:0] trackTag_q [NSTAGE];
    logic [31:0]     memY_q   [DEPTH];
    logic            memOvf_q [DEPTH];
    logic [TAGW-1:0] memTag_q [DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            issReady_q, issReady_d;
    logic            protoErr_q, protoErr_d;

    logic            accept, expVld, capture, resValid, pop, full, push, pushDrop;
    logic [SW-1:0]   inflight_d;

    // Handshake decode. The tracker's last stage is the op the fsub should be
    // returning this cycle. A push into a full FIFO is still allowed when the
    // head leaves in the same cycle. The readiness for the next cycle comes
    // from the post-edge occupancy, so a pop only frees credit a cycle later.
    always_comb begin
        accept     = iss_valid && issReady_q;
        expVld     = trackVld_q[NSTAGE-1];
        capture    = fpu_enable_out && expVld;
        resValid   = (count_q != '0);
        pop        = resValid && res_ready;
        full       = (count_q == CW'(DEPTH));
        push       = capture && (!full || pop);
        pushDrop   = capture && full && !pop;
        protoErr_d = protoErr_q || (fpu_enable_out != expVld) || pushDrop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        inflight_d = SW'(accept);
        for (int i = 0; i < NSTAGE - 1; i++) begin
            inflight_d = inflight_d + SW'(trackVld_q[i]);
        end
        issReady_d = (SW'(count_d) + inflight_d) < SW'(DEPTH);
    end

    // Control state: operand registers, the tag tracker, FIFO pointers and
    // count, and the credit and error flags. A reset empties everything,
    // which discards any op still inside the fsub together with its tag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fpuX1_q    <= '0;
            fpuX2_q    <= '0;
            fpuEnIn_q  <= 1'b0;
            trackVld_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                trackTag_q[i] <= '0;
            end
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            issReady_q <= 1'b0;
            protoErr_q <= 1'b0;
        end else begin
            fpuEnIn_q <= accept;
            if (accept) begin
                fpuX1_q <= iss_x1;
                fpuX2_q <= iss_x2;
            end
            trackVld_q[0] <= accept;
            trackTag_q[0] <= iss_tag;
            for (int i = 1; i < NSTAGE; i++) begin
                trackVld_q[i] <= trackVld_q[i-1];
                trackTag_q[i] <= trackTag_q[i-1];
            end
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q    <= count_d;
            issReady_q <= issReady_d;
            protoErr_q <= protoErr_d;
        end
    end

    // FIFO storage has no reset. The head is masked to zero while the FIFO is
    // empty, so stale entries never become visible.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            memY_q[wrPtr_q]   <= fpu_y;
            memOvf_q[wrPtr_q] <= fpu_ovf;
            memTag_q[wrPtr_q] <= trackTag_q[NSTAGE-1];
        end
    end

    assign iss_ready     = issReady_q;
    assign fpu_x1        = fpuX1_q;
    assign fpu_x2        = fpuX2_q;
    assign fpu_enable_in = fpuEnIn_q;
    assign res_valid     = resValid;
    assign res_y         = resValid ? memY_q[rdPtr_q]   : '0;
    assign res_ovf       = resValid ? memOvf_q[rdPtr_q] : 1'b0;
    assign res_tag       = resValid ? memTag_q[rdPtr_q] : '0;
    assign proto_err     = protoErr_q;

endmodule

// File: tb/tb_fsub_issue_wb.sv
// Testbench for fsub_issue_wb.
// A stand-in fsub answers enable_in with enable_out after the delay that the
// shell's tag tracker expects. The reference model is a queue of accepted ops.
// Each queued op carries the cycle from which its result may appear, and the
// issue credit is simply "fewer than DEPTH ops accepted but not yet retired".
module tb_fsub_issue_wb;

    localparam int NSTAGE = 2;
    localparam int DEPTH  = 4;
    localparam int TAGW   = 5;
    localparam int LAT    = NSTAGE - 1;

    logic            clk, rstn;
    logic            iss_valid, iss_ready;
    logic [31:0]     iss_x1, iss_x2;
    logic [TAGW-1:0] iss_tag;
    logic [31:0]     fpu_x1, fpu_x2;
    logic            fpu_enable_in, fpu_enable_out;
    logic [31:0]     fpu_y;
    logic            fpu_ovf;
    logic            res_valid, res_ready;
    logic [31:0]     res_y;
    logic            res_ovf;
    logic [TAGW-1:0] res_tag;
    logic            proto_err;
    logic            forceOut;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 0;
    bit modelErr  = 0;
    bit autoCheck = 0;

    typedef struct {
        logic [31:0]     y;
        logic            ovf;
        logic [TAGW-1:0] tag;
        int              avail;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        logic [31:0]     x1;
        logic [31:0]     x2;
        logic [TAGW-1:0] tag;
        logic [31:0]     expY;
        logic            expOvf;
    } vec_t;
    vec_t vecs[5];

    fsub_issue_wb #(.NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_x1(iss_x1), .iss_x2(iss_x2), .iss_tag(iss_tag),
        .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_enable_in(fpu_enable_in),
        .fpu_enable_out(fpu_enable_out), .fpu_y(fpu_y), .fpu_ovf(fpu_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_ovf(res_ovf), .res_tag(res_tag),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // This arithmetic stands in for the fsub. Two real subtractions are
    // spelled out, and any other pair gets an arbitrary but deterministic
    // answer. The shell only carries the value through.
    function automatic logic [32:0] fsubModel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F000000) return {1'b0, 32'h3F000000};
        if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF) return {1'b1, 32'h7F800000};
        return {a[31] & ~b[31], a ^ b};
    endfunction

    // The stand-in fsub pipeline. It is flushed by the same reset as the shell.
    logic        stubV [LAT];
    logic [31:0] stubY [LAT];
    logic        stubO [LAT];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) stubV[i] <= 1'b0;
        end else begin
            stubV[0] <= fpu_enable_in;
            {stubO[0], stubY[0]} <= fsubModel(fpu_x1, fpu_x2);
            for (int i = 1; i < LAT; i++) begin
                stubV[i] <= stubV[i-1];
                stubY[i] <= stubY[i-1];
                stubO[i] <= stubO[i-1];
            end
        end
    end
    assign fpu_enable_out = stubV[LAT-1] | forceOut;
    assign fpu_y          = stubY[LAT-1];
    assign fpu_ovf        = stubO[LAT-1];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit modelReady();
        return armed && (expQ.size() < DEPTH);
    endfunction

    function automatic bit headVisible();
        return (expQ.size() > 0) && (expQ[0].avail <= cyc);
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                                 input logic [TAGW-1:0] tag, input logic rr);
        iss_valid = v;
        iss_x1    = x1;
        iss_x2    = x2;
        iss_tag   = tag;
        res_ready = rr;
    endtask

    task automatic checkOutput();
        compare("iss_ready", {31'b0, iss_ready}, {31'b0, modelReady()});
        compare("res_valid", {31'b0, res_valid}, {31'b0, headVisible()});
        if (headVisible()) begin
            compare("res_y", res_y, expQ[0].y);
            compare("res_ovf", {31'b0, res_ovf}, {31'b0, expQ[0].ovf});
            compare("res_tag", 32'(res_tag), 32'(expQ[0].tag));
        end
        compare("proto_err", {31'b0, proto_err}, {31'b0, modelErr});
    endtask

    // One clock: decide what the edge does from the model, advance the model,
    // then sample the DUT 1 time unit after the edge.
    task automatic stepCycle();
        bit              acc, pp;
        logic [32:0]     r;
        logic [TAGW-1:0] t;
        acc = (rstn === 1'b1) && iss_valid && modelReady();
        pp  = (rstn === 1'b1) && headVisible() && res_ready;
        r   = fsubModel(iss_x1, iss_x2);
        t   = iss_tag;
        @(posedge clk);
        cyc++;
        if (rstn !== 1'b1) begin
            expQ.delete();
            armed    = 0;
            modelErr = 0;
        end else begin
            if (pp) void'(expQ.pop_front());
            if (acc) expQ.push_back('{y: r[31:0], ovf: r[32], tag: t, avail: cyc + NSTAGE});
            if (forceOut) modelErr = 1;
            armed = 1;
        end
        #1;
        if (autoCheck) checkOutput();
    endtask

    task automatic checkResetOutputs(input string tagName);
        compare({tagName, "_iss_ready"}, {31'b0, iss_ready}, 32'd0);
        compare({tagName, "_fpu_en_in"}, {31'b0, fpu_enable_in}, 32'd0);
        compare({tagName, "_fpu_x1"}, fpu_x1, 32'd0);
        compare({tagName, "_fpu_x2"}, fpu_x2, 32'd0);
        compare({tagName, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        compare({tagName, "_res_y"}, res_y, 32'd0);
        compare({tagName, "_res_ovf"}, {31'b0, res_ovf}, 32'd0);
        compare({tagName, "_res_tag"}, 32'(res_tag), 32'd0);
        compare({tagName, "_proto_err"}, {31'b0, proto_err}, 32'd0);
    endtask

    initial begin
        int waited, nres, bubbles, stallLeft;
        int accTags[$];
        int gotTags[$];
        logic v, rr;
        logic [31:0] x1, x2;

        vecs[0] = '{x1: 32'h3F800000, x2: 32'h3F000000, tag: 5'd5,  expY: 32'h3F000000, expOvf: 1'b0};
        vecs[1] = '{x1: 32'h7F7FFFFF, x2: 32'hFF7FFFFF, tag: 5'd9,  expY: 32'h7F800000, expOvf: 1'b1};
        vecs[2] = '{x1: 32'hC0000000, x2: 32'h40000000, tag: 5'd0,  expY: 32'h80000000, expOvf: 1'b1};
        vecs[3] = '{x1: 32'hFFFFFFFF, x2: 32'hFFFFFFFF, tag: 5'd31, expY: 32'h00000000, expOvf: 1'b0};
        vecs[4] = '{x1: 32'h12345678, x2: 32'h0000FFFF, tag: 5'd17, expY: 32'h1234A987, expOvf: 1'b0};

        rstn = 1'b0;
        forceOut = 1'b0;
        applyStimulus(0, 32'd0, 32'd0, '0, 0);
        stepCycle();
        stepCycle();
        checkResetOutputs("reset");
        autoCheck = 1;
        rstn = 1'b1;
        stepCycle();
        compare("ready_after_reset", {31'b0, iss_ready}, 32'd1);

        // Single ops from the table: latency, pass-through, one-beat result.
        foreach (vecs[k]) begin
            applyStimulus(1, vecs[k].x1, vecs[k].x2, vecs[k].tag, 1);
            stepCycle();
            compare("vec_fpu_en_in", {31'b0, fpu_enable_in}, 32'd1);
            compare("vec_fpu_x1", fpu_x1, vecs[k].x1);
            compare("vec_fpu_x2", fpu_x2, vecs[k].x2);
            applyStimulus(0, 32'd0, 32'd0, '0, 1);
            waited = 0;
            while (!res_valid && waited < 10) begin
                stepCycle();
                waited++;
            end
            compare("vec_latency", 32'(waited), 32'(NSTAGE));
            compare("vec_y", res_y, vecs[k].expY);
            compare("vec_ovf", {31'b0, res_ovf}, {31'b0, vecs[k].expOvf});
            compare("vec_tag", 32'(res_tag), 32'(vecs[k].tag));
            compare("vec_proto_err", {31'b0, proto_err}, 32'd0);
            stepCycle();
            compare("vec_single_beat", {31'b0, res_valid}, 32'd0);
        end

        // Credit limit: the consumer is stalled while eight ops are offered.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'(i), 32'd0, TAGW'(i), 0);
            if (iss_ready) accTags.push_back(i);
            stepCycle();
        end
        applyStimulus(0, 32'd0, 32'd0, '0, 0);
        compare("credit_accepts", 32'(accTags.size()), 32'(DEPTH));
        for (int k = 0; k < accTags.size() && k < DEPTH; k++)
            compare("credit_tag", 32'(accTags[k]), 32'(k));
        compare("credit_full_ready", {31'b0, iss_ready}, 32'd0);
        res_ready = 1'b1;
        for (int n = 0; n < 20 && gotTags.size() < DEPTH; n++) begin
            if (res_valid) gotTags.push_back(int'(res_tag));
            stepCycle();
        end
        compare("drain_count", 32'(gotTags.size()), 32'(DEPTH));
        for (int k = 0; k < gotTags.size(); k++)
            compare("drain_order", 32'(gotTags[k]), 32'(k));
        compare("issue_resumes", {31'b0, iss_ready}, 32'd1);

        // Back-to-back issue: one result per cycle once the pipeline fills.
        nres = 0;
        bubbles = 0;
        for (int c = 0; c < 12 + NSTAGE + 4; c++) begin
            if (c < 12) begin
                applyStimulus(1, $urandom, $urandom, TAGW'(c), 1);
                compare("b2b_ready", {31'b0, iss_ready}, 32'd1);
            end else begin
                applyStimulus(0, 32'd0, 32'd0, '0, 1);
            end
            if (res_valid) begin
                compare("b2b_tag", 32'(res_tag), 32'(nres));
                nres++;
            end else if (nres > 0 && nres < 12) begin
                bubbles++;
            end
            stepCycle();
        end
        compare("b2b_count", 32'(nres), 32'd12);
        compare("b2b_bubbles", 32'(bubbles), 32'd0);

        // A spurious enable_out while idle sets a sticky error and pushes nothing.
        applyStimulus(0, 32'd0, 32'd0, '0, 1);
        forceOut = 1'b1;
        stepCycle();
        forceOut = 1'b0;
        compare("spurious_err", {31'b0, proto_err}, 32'd1);
        compare("spurious_empty", {31'b0, res_valid}, 32'd0);
        repeat (3) stepCycle();
        compare("spurious_sticky", {31'b0, proto_err}, 32'd1);
        compare("spurious_still_empty", {31'b0, res_valid}, 32'd0);

        // Reset while three ops are in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, $urandom, $urandom, TAGW'(20 + i), 0);
            stepCycle();
        end
        applyStimulus(0, 32'd0, 32'd0, '0, 0);
        rstn = 1'b0;
        stepCycle();
        checkResetOutputs("midreset");
        rstn = 1'b1;
        stepCycle();
        compare("midreset_ready", {31'b0, iss_ready}, 32'd1);
        res_ready = 1'b1;
        repeat (6) begin
            stepCycle();
            compare("midreset_no_stale", {31'b0, res_valid}, 32'd0);
        end

        // Random traffic with consumer stalls, checked each cycle against the model.
        stallLeft = 0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            x1 = $urandom;
            x2 = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                x1 = 32'h7F7FFFFF;
                x2 = 32'hFF7FFFFF;
            end
            if (stallLeft > 0) begin
                rr = 1'b0;
                stallLeft--;
            end else begin
                if ($urandom_range(0, 19) == 0) stallLeft = $urandom_range(3, 8);
                rr = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(v, x1, x2, TAGW'($urandom_range(0, 31)), rr);
            stepCycle();
        end
        applyStimulus(0, 32'd0, 32'd0, '0, 1);
        for (int n = 0; n < 40 && expQ.size() > 0; n++) stepCycle();
        stepCycle();
        compare("final_drained", {31'b0, res_valid}, 32'd0);
        compare("final_proto_err", {31'b0, proto_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
